// File: rtl/avalon_pio_master_if.sv
// avalon_pio_master_if: command, response and Avalon-MM PIO signals of avalon_pio_master
interface avalon_pio_master_if #(
  parameter int ADDR_W = 2
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_address;
  logic [31:0]       cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic [ADDR_W-1:0] av_address;
  logic              av_chipselect;
  logic              av_write_n;
  logic              av_read_n;
  logic [31:0]       av_writedata;
  logic [31:0]       av_readdata;
  logic              busy;
  modport master (
    input  cmd_valid, cmd_write, cmd_address, cmd_wdata, rsp_ready, av_readdata,
    output cmd_ready, rsp_valid, rsp_rdata, av_address, av_chipselect, av_write_n,
           av_read_n, av_writedata, busy
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_address, cmd_wdata, rsp_ready, av_readdata,
    input  cmd_ready, rsp_valid, rsp_rdata, av_address, av_chipselect, av_write_n,
           av_read_n, av_writedata, busy
  );
endinterface

// File: rtl/avalon_pio_master.sv
// avalon_pio_master: FIFO-buffered valid/ready command stream to single-cycle Avalon-MM PIO transfers
module avalon_pio_master #(
  parameter int ADDR_W    = 2,
  parameter int CMD_DEPTH = 4,
  parameter int GAP_CYC   = 0
) (
  input logic clk,
  input logic reset_n,
  avalon_pio_master_if.master bus
);
  localparam int PW = $clog2(CMD_DEPTH);
  localparam int CW = $clog2(CMD_DEPTH + 1);
  // the mandatory IDLE pop cycle is one of the GAP_CYC idle cycles, so GAP itself runs GAP_CYC-1
  localparam bit         USE_GAP  = GAP_CYC > 1;
  localparam logic [3:0] GAP_LOAD = USE_GAP ? 4'(GAP_CYC - 2) : 4'd0;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP, GAP} state_t;
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [31:0]       wdata;
  } cmd_t;
  cmd_t          mem [CMD_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [3:0]    gap_cnt;
  state_t        state, state_nx;
  logic          push, pop;
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign pop           = state == IDLE && count != '0;
  assign bus.cmd_ready = count != CW'(CMD_DEPTH);
  assign bus.busy      = count != '0 || state != IDLE;
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = pop ? ISSUE : IDLE;
    else if (state == ISSUE) state_nx = bus.av_write_n ? RESP : USE_GAP ? GAP : IDLE;
    else if (state == RESP) state_nx = !bus.rsp_ready ? RESP : USE_GAP ? GAP : IDLE;
    else state_nx = gap_cnt == '0 ? IDLE : GAP;
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= '{write: bus.cmd_write, address: bus.cmd_address, wdata: bus.cmd_wdata};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state             <= IDLE;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      gap_cnt           <= '0;
      bus.av_address    <= '0;
      bus.av_writedata  <= '0;
      bus.av_chipselect <= 1'b0;
      bus.av_write_n    <= 1'b1;
      bus.av_read_n     <= 1'b1;
      bus.rsp_valid     <= 1'b0;
      bus.rsp_rdata     <= '0;
    end else begin
      state   <= state_nx;
      wr_ptr  <= wr_ptr + PW'(push);
      rd_ptr  <= rd_ptr + PW'(pop);
      count   <= count + CW'(push) - CW'(pop);
      gap_cnt <= state == GAP ? gap_cnt - 4'(gap_cnt != '0) : GAP_LOAD;
      if (pop) begin
        bus.av_address   <= mem[rd_ptr].address;
        bus.av_writedata <= mem[rd_ptr].wdata;
      end
      bus.av_chipselect <= state_nx == ISSUE;
      bus.av_write_n    <= !(state_nx == ISSUE && mem[rd_ptr].write);
      bus.av_read_n     <= !(state_nx == ISSUE && !mem[rd_ptr].write);
      bus.rsp_valid     <= state_nx == RESP;
      if (!bus.av_read_n) bus.rsp_rdata <= bus.av_readdata;
    end
endmodule

// File: tb/tb_avalon_pio_master.sv
// tb_avalon_pio_master: directed and random checks of avalon_pio_master against a PIO responder model
module tb_avalon_pio_master;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;
  avalon_pio_master_if #(.ADDR_W(2)) bus ();
  avalon_pio_master_if #(.ADDR_W(2)) gbus ();
  avalon_pio_master #(.ADDR_W(2), .CMD_DEPTH(4), .GAP_CYC(0)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  avalon_pio_master #(.ADDR_W(2), .CMD_DEPTH(4), .GAP_CYC(3)) u_gap (.clk(clk), .reset_n(reset_n), .bus(gbus));
  // LED PIO responder: data register at word 0, zero-latency read, other words read as 0
  logic [31:0] pio_reg = 32'd0;
  always @(posedge clk)
    if (bus.av_chipselect && !bus.av_write_n && bus.av_address == 2'd0) pio_reg <= bus.av_writedata;
  assign bus.av_readdata  = bus.av_address == 2'd0 ? pio_reg : 32'd0;
  assign gbus.av_readdata = 32'd0;
  typedef struct packed {
    logic       w;
    logic [1:0] a;
    logic [31:0] d;
  } cmd_t;
  cmd_t        exp_q[$];
  logic [31:0] rsp_q[$];
  int          st_q[$];
  int          g_t[$];
  int          total = 0, bad = 0, cyc = 0, nstrobe = 0;
  logic        prev_cs = 1'b0;
  logic [31:0] m_led = 32'd0;
  bit          rnd_ready = 1'b0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    cmd_t e;
    if (bus.cmd_valid && bus.cmd_ready) begin
      exp_q.push_back('{w: bus.cmd_write, a: bus.cmd_address, d: bus.cmd_wdata});
      if (!bus.cmd_write) rsp_q.push_back(bus.cmd_address == 2'd0 ? m_led : 32'd0);
      if (bus.cmd_write && bus.cmd_address == 2'd0) m_led = bus.cmd_wdata;
    end
    if (bus.rsp_valid && bus.rsp_ready) begin
      chk("rsp_expected", 64'(rsp_q.size() > 0), 64'd1);
      if (rsp_q.size() > 0) chk("rsp_rdata", bus.rsp_rdata, rsp_q.pop_front());
    end
    @(posedge clk);
    #1;
    cyc++;
    if (bus.av_chipselect) begin
      nstrobe++;
      st_q.push_back(cyc);
      chk("strobe_width", prev_cs, 0);
      chk("strobe_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("bus_cmd", {bus.av_write_n, bus.av_read_n, bus.av_address, e.w ? bus.av_writedata : 32'd0},
            {!e.w, e.w, e.a, e.w ? e.d : 32'd0});
      end
    end
    prev_cs = bus.av_chipselect;
  endtask
  task automatic send(input logic w, input logic [1:0] a, input logic [31:0] d);
    bit acc;
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_address = a;
    bus.cmd_wdata = d;
    do begin
      if (rnd_ready) bus.rsp_ready = $urandom_range(0, 3) != 0;
      acc = bus.cmd_ready;
      tick();
      n++;
    end while (!acc && n < 100);
    if (!acc) chk("send_timeout", 0, 1);
    bus.cmd_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || bus.rsp_valid || exp_q.size() > 0) && n < 400) begin
      tick();
      n++;
    end
    chk("idle_timeout", 64'(n < 400), 64'd1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int ns;
    logic [31:0] m_save;
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_address = 0; bus.cmd_wdata = 0; bus.rsp_ready = 1;
    gbus.cmd_valid = 0; gbus.cmd_write = 0; gbus.cmd_address = 0; gbus.cmd_wdata = 0; gbus.rsp_ready = 1;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", {bus.cmd_ready, bus.busy, bus.rsp_valid, bus.av_chipselect, bus.av_write_n, bus.av_read_n}, 6'b100011);
    chk("rst_addr_data", {bus.av_address, bus.av_writedata, bus.rsp_rdata}, 0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_flags", {bus.cmd_ready, bus.busy, bus.av_chipselect}, 3'b100);
    // write 3 to the LED PIO: strobe two cycles after acceptance
    send(1'b1, 2'd0, 32'h3);
    chk("w1_no_strobe_yet", bus.av_chipselect, 0);
    tick();
    chk("w1_strobe", {bus.av_chipselect, bus.av_write_n, bus.av_read_n, bus.av_address}, 5'b10100);
    chk("w1_wdata", bus.av_writedata, 32'h3);
    tick();
    chk("w1_release", {bus.av_chipselect, bus.av_write_n, bus.av_read_n}, 3'b011);
    chk("led_out_port", pio_reg[1:0], 2'b11);
    // read back word 0 with the response held, then word 1
    bus.rsp_ready = 1'b0;
    send(1'b0, 2'd0, 32'h0);
    tick();
    chk("r0_strobe", {bus.av_chipselect, bus.av_write_n, bus.av_read_n}, 3'b110);
    tick();
    chk("r0_rsp", {bus.rsp_valid, bus.rsp_rdata}, {1'b1, 32'h3});
    tick();
    chk("r0_rsp_held", {bus.rsp_valid, bus.rsp_rdata}, {1'b1, 32'h3});
    bus.rsp_ready = 1'b1;
    tick();
    chk("r0_rsp_done", bus.rsp_valid, 0);
    send(1'b0, 2'd1, 32'h0);
    wait_idle();
    chk("r1_rdata", bus.rsp_rdata, 32'h0);
    // pending response blocks the bus while the FIFO fills
    bus.rsp_ready = 1'b0;
    send(1'b0, 2'd0, 32'h0);
    send(1'b1, 2'd0, 32'h5);
    send(1'b1, 2'd1, 32'h6);
    send(1'b1, 2'd0, 32'h7);
    send(1'b1, 2'd2, 32'h8);
    chk("full_cmd_ready", {bus.cmd_ready, bus.rsp_valid}, 2'b01);
    ns = nstrobe;
    repeat (4) tick();
    chk("blocked_no_strobe", nstrobe, ns);
    chk("blocked_busy", bus.busy, 1);
    bus.rsp_ready = 1'b1;
    wait_idle();
    chk("drain_strobes", nstrobe, ns + 4);
    for (int k = 1; k < 4; k++)
      chk("b2b_spacing", st_q[st_q.size() - k] - st_q[st_q.size() - k - 1], 2);
    chk("led_after_drain", pio_reg, 32'h7);
    // GAP_CYC=3 instance: three idle bus cycles between two queued writes
    chk("gap_ready", gbus.cmd_ready, 1);
    gbus.cmd_valid = 1'b1; gbus.cmd_write = 1'b1; gbus.cmd_address = 2'd0; gbus.cmd_wdata = 32'h1;
    tick();
    gbus.cmd_wdata = 32'h2;
    tick();
    gbus.cmd_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (gbus.av_chipselect) g_t.push_back(cyc);
      tick();
    end
    chk("gap_strobes", g_t.size(), 2);
    if (g_t.size() == 2) chk("gap_spacing", g_t[1] - g_t[0], 4);
    chk("gap_idle", gbus.busy, 0);
    // reset during the ISSUE cycle of a write with another write queued
    m_save = m_led;
    send(1'b1, 2'd0, 32'hA);
    send(1'b1, 2'd1, 32'hB);
    chk("rst_issue_cs", {bus.av_chipselect, bus.av_write_n}, 2'b10);
    reset_n = 1'b0;
    #1;
    chk("rst_async_release", {bus.av_chipselect, bus.av_write_n, bus.av_read_n}, 3'b011);
    chk("rst_async_state", {bus.busy, bus.cmd_ready, bus.rsp_valid}, 3'b010);
    exp_q.delete();
    rsp_q.delete();
    m_led = m_save;
    prev_cs = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    ns = nstrobe;
    repeat (10) tick();
    chk("rst_no_strobes", nstrobe, ns);
    chk("rst_after_flags", {bus.busy, bus.cmd_ready}, 2'b01);
    chk("rst_led_kept", pio_reg, 32'h7);
    // random mixed stream against the responder model
    rnd_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
      if ($urandom_range(0, 3) == 0) tick();
    end
    rnd_ready = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_idle();
    chk("rnd_queues_empty", {32'(exp_q.size()), 32'(rsp_q.size())}, 0);
    chk("rnd_led", pio_reg, m_led);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
